ser_tx: RTL and testbench



---
 rtl/ser_tx_pkg.sv | 15 +
 rtl/bit_tick_gen.sv | 29 ++
 rtl/ser_tx.sv | 89 ++++++++
 tb/tb_ser_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_tx_pkg.sv
// Shared types and helpers for the serial transmitter.
package ser_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width for a count range of n; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: one-cycle tick every DIV cycles, restartable via load.
module bit_tick_gen
    import ser_tx_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = ctr_width(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/ser_tx.sv
// Parametrised serial transmitter: valid/ready word intake, programmable bit
// period, selectable shift order, abort and restart support.
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int LSB_FIRST = 0,
    parameter int RESTART   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             abort,
    // Serial output; `bit` is a reserved word, hence ser_bit.
    output logic             ser_bit,
    output logic             busy,
    output logic             finish
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;
    localparam int BW = ctr_width(WIDTH);

    logic [1:0]       state;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             in_shift;
    logic             accept;
    logic             tick;

    assign in_shift = (state == S_SHIFT);
    assign ready    = !in_shift || (RESTART != 0);
    assign accept   = valid && ready && !abort;

    // The output bit is always the leading end of the shift register, so the
    // last bit naturally holds in DONE and clearing the register zeroes it.
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign ser_bit   = shreg[0];
            assign shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        end else begin : g_msb
            assign ser_bit   = shreg[WIDTH-1];
            assign shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bcnt   <= '0;
            busy   <= 1'b0;
            finish <= 1'b1;
        end else if (abort && in_shift) begin
            state  <= S_IDLE;
            shreg  <= '0;
            busy   <= 1'b0;
            finish <= 1'b0;
        end else if (accept) begin
            state  <= S_SHIFT;
            shreg  <= data;
            bcnt   <= BW'(WIDTH - 1);
            busy   <= 1'b1;
            finish <= 1'b0;
        end else if (in_shift && tick) begin
            if (bcnt != '0) begin
                shreg <= shreg_nxt;
                bcnt  <= bcnt - 1'b1;
            end else begin
                state  <= S_DONE;
                busy   <= 1'b0;
                finish <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// Scoreboard bench for ser_tx: three configurations share one stimulus bus.
module tb_ser_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       abort;
    logic [7:0] data;
    logic [2:0] ser_bit, ready, busy, finish;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    // 0: MSB-first DIV=1 restart; 1: LSB-first DIV=3 restart; 2: MSB-first DIV=1 no restart
    ser_tx #(.WIDTH(8), .DIV(1), .LSB_FIRST(0), .RESTART(1)) u_msb (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready[0]),
        .abort(abort), .ser_bit(ser_bit[0]), .busy(busy[0]), .finish(finish[0]));
    ser_tx #(.WIDTH(8), .DIV(3), .LSB_FIRST(1), .RESTART(1)) u_lsb (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready[1]),
        .abort(abort), .ser_bit(ser_bit[1]), .busy(busy[1]), .finish(finish[1]));
    ser_tx #(.WIDTH(8), .DIV(1), .LSB_FIRST(0), .RESTART(0)) u_nrs (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready[2]),
        .abort(abort), .ser_bit(ser_bit[2]), .busy(busy[2]), .finish(finish[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w, input logic lsb, input int div);
        for (int i = 0; i < 8; i++)
            for (int r = 0; r < div; r++)
                exp_q.push_back(lsb ? w[i] : w[7-i]);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; abort = 1'b0; data = '0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({ser_bit[k], busy[k], finish[k], ready[k]} !== 4'b0011) begin
                n_fail++;
                $display("FAIL reset[%0d] bit/busy/finish/ready got %b expected 0011", k,
                         {ser_bit[k], busy[k], finish[k], ready[k]});
            end
        end
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if ({ser_bit[0], busy[0], finish[0], ready[0]} !== 4'b0011) begin
                n_fail++;
                $display("FAIL idle cycle %0d got %b expected 0011", c,
                         {ser_bit[0], busy[0], finish[0], ready[0]});
            end
        end
    endtask

    task automatic test_msb_first();
        logic e;
        do_reset();
        data = 8'b00110101; valid = 1'b1;
        step();
        valid = 1'b0;
        push_word(8'b00110101, 1'b0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[0] !== e || busy[0] !== 1'b1 || finish[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL msb bit got %b busy %b finish %b expected %b 1 0",
                         ser_bit[0], busy[0], finish[0], e);
            end
            step();
        end
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if ({ser_bit[0], busy[0], finish[0], ready[0]} !== 4'b1011) begin
                n_fail++;
                $display("FAIL msb done cycle %0d got %b expected 1011", c,
                         {ser_bit[0], busy[0], finish[0], ready[0]});
            end
            if (c < 3) step();
        end
    endtask

    task automatic test_lsb_div();
        logic e;
        do_reset();
        data = 8'b11001100; valid = 1'b1;
        step();
        valid = 1'b0;
        push_word(8'b11001100, 1'b1, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[1] !== e || busy[1] !== 1'b1 || finish[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL lsb_div bit got %b busy %b finish %b expected %b 1 0 (left %0d)",
                         ser_bit[1], busy[1], finish[1], e, exp_q.size());
            end
            step();
        end
        n_tests++;
        if ({busy[1], finish[1], ready[1]} !== 3'b011) begin
            n_fail++;
            $display("FAIL lsb_div finish got %b expected 011", {busy[1], finish[1], ready[1]});
        end
    endtask

    task automatic test_restart();
        logic e;
        do_reset();
        data = 8'b00110101; valid = 1'b1;
        step();
        valid = 1'b0;
        push_word(8'b00110101, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[0] !== e || finish[0] !== 1'b0 || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL restart first word bit %0d got %b finish %b expected %b 0",
                         i, ser_bit[0], finish[0], e);
            end
            if (i == 2) begin
                data = 8'b00101001; valid = 1'b1;
            end
            step();
        end
        valid = 1'b0;
        exp_q.delete();
        push_word(8'b00101001, 1'b0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[0] !== e || finish[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL restart second word bit got %b finish %b expected %b 0",
                         ser_bit[0], finish[0], e);
            end
            step();
        end
        n_tests++;
        if ({busy[0], finish[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL restart finish got %b expected 01", {busy[0], finish[0]});
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        do_reset();
        data = 8'b11110000; valid = 1'b1;
        step();
        data = 8'b00001111;
        push_word(8'b11110000, 1'b0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[2] !== e || ready[2] !== 1'b0 || busy[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL no_restart word1 bit got %b ready %b busy %b expected %b 0 1",
                         ser_bit[2], ready[2], busy[2], e);
            end
            step();
        end
        n_tests++;
        if ({busy[2], finish[2], ready[2]} !== 3'b011) begin
            n_fail++;
            $display("FAIL no_restart done got %b expected 011", {busy[2], finish[2], ready[2]});
        end
        step();
        valid = 1'b0;
        n_tests++;
        if ({busy[2], finish[2]} !== 2'b10) begin
            n_fail++;
            $display("FAIL no_restart second accept got %b expected 10", {busy[2], finish[2]});
        end
        push_word(8'b00001111, 1'b0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[2] !== e) begin
                n_fail++;
                $display("FAIL no_restart word2 bit got %b expected %b", ser_bit[2], e);
            end
            step();
        end
        n_tests++;
        if (finish[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL no_restart word2 finish got %b expected 1", finish[2]);
        end
    endtask

    task automatic test_abort();
        logic e;
        do_reset();
        data = 8'b00110101; valid = 1'b1;
        step();
        valid = 1'b0;
        push_word(8'b00110101, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ser_bit[0] !== e) begin
                n_fail++;
                $display("FAIL abort pre bit %0d got %b expected %b", i, ser_bit[0], e);
            end
            step();
        end
        exp_q.delete();
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({ser_bit[0], busy[0], finish[0], ready[0]} !== 4'b0001) begin
                n_fail++;
                $display("FAIL abort cycle %0d got %b expected 0001", c,
                         {ser_bit[0], busy[0], finish[0], ready[0]});
            end
            step();
        end

        // Same point in the word, but reset instead of abort.
        data = 8'b00110101; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({ser_bit[0], busy[0], finish[0], ready[0]} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset mid-word got %b expected 0011",
                     {ser_bit[0], busy[0], finish[0], ready[0]});
        end

        // Abort and a new valid word on the same edge.
        data = 8'b00110101; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        step();
        abort = 1'b1; valid = 1'b1; data = 8'hFF;
        step();
        abort = 1'b0; valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({ser_bit[0], busy[0], finish[0], ready[0]} !== 4'b0001) begin
                n_fail++;
                $display("FAIL abort+valid cycle %0d got %b expected 0001", c,
                         {ser_bit[0], busy[0], finish[0], ready[0]});
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_div();
        test_restart();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
